// File: rtl/branch_resolve_unit.sv
// Branch resolve queue: checks oldest prediction at EX/MEM, flushes with corrected PC on mispredict (1-cycle latency).
// Stalls decode via comb full; optional BRU_STATS_EN adds branch/mispredict counters.
module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  input  logic        dec_pred,
  input  logic [31:0] dec_pc,
  input  logic [31:0] dec_offset,
  input  logic        ex_valid,
  input  logic        ex_taken,
  output logic        full,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        actual_branch_decision,
  output logic        branch_mem_sig,
  output logic        overflow,
`ifdef BRU_STATS_EN
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
`endif
  output logic        underflow
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {RUN, RECOVER} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic [DEPTH-1:0] pred_q;
  logic [31:0]      fall_q [DEPTH];
  logic [31:0]      tgt_q  [DEPTH];

  logic        flush_q, flush_d;
  logic [31:0] redirect_q, redirect_d;
  logic        abd_q, abd_d;
  logic        mem_sig_q, mem_sig_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic          empty, run, pop, push, mispredict;
  logic [PW-1:0] head_idx, wr_idx;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_idx = rd_ptr_q[PW-1:0];
  assign wr_idx   = wr_ptr_q[PW-1:0];

  assign run        = (state_q == RUN);
  assign pop        = run && ex_valid && !empty;
  // A pop in the same cycle frees the slot, so a push while full is still accepted.
  assign push       = run && dec_valid && (!full || pop);
  assign mispredict = pop && (pred_q[head_idx] != ex_taken);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    flush_d    = flush_q;
    redirect_d = redirect_q;
    abd_d      = pop ? ex_taken : abd_q;
    mem_sig_d  = pop;
    ovf_d      = ovf_q | (run && dec_valid && full && !pop);
    unf_d      = unf_q | (run && ex_valid && empty);
    case (state_q)
      RUN: begin
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        // Everything younger than a mispredicted branch is wrong-path, including this cycle's push.
        if (mispredict) begin
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          redirect_d = ex_taken ? tgt_q[head_idx] : fall_q[head_idx];
          state_d    = RECOVER;
          flush_d    = 1'b1;
          cnt_d      = 4'(FLUSH_CYCLES - 1);
        end
      end
      RECOVER: begin
        if (cnt_q == 4'd0) begin
          state_d = RUN;
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      abd_q      <= 1'b0;
      mem_sig_q  <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      abd_q      <= abd_d;
      mem_sig_q  <= mem_sig_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pred_q[wr_idx] <= dec_pred;
      fall_q[wr_idx] <= dec_pc + 32'd4;
      tgt_q[wr_idx]  <= dec_pc + dec_offset;
    end
  end

  assign flush                  = flush_q;
  assign redirect_pc            = redirect_q;
  assign actual_branch_decision = abd_q;
  assign branch_mem_sig         = mem_sig_q;
  assign overflow               = ovf_q;
  assign underflow              = unf_q;

`ifdef BRU_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (pop)        stat_br_q <= stat_br_q + 32'd1;
      if (mispredict) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; covers BRU_STATS_EN counters when that macro is defined.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid, dec_pred, ex_valid, ex_taken;
  logic [31:0] dec_pc, dec_offset;
  logic        full, flush, actual_branch_decision, branch_mem_sig, overflow, underflow;
  logic [31:0] redirect_pc;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk),
    .reset(reset),
    .dec_valid(dec_valid),
    .dec_pred(dec_pred),
    .dec_pc(dec_pc),
    .dec_offset(dec_offset),
    .ex_valid(ex_valid),
    .ex_taken(ex_taken),
    .full(full),
    .flush(flush),
    .redirect_pc(redirect_pc),
    .actual_branch_decision(actual_branch_decision),
    .branch_mem_sig(branch_mem_sig),
    .overflow(overflow),
`ifdef BRU_STATS_EN
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts),
`endif
    .underflow(underflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic dv, input logic dp, input logic [31:0] pc, input logic [31:0] off,
                     input logic ev, input logic et);
    dec_valid  = dv;
    dec_pred   = dp;
    dec_pc     = pc;
    dec_offset = off;
    ex_valid   = ev;
    ex_taken   = et;
    @(posedge clk);
    #1;
    dec_valid = 1'b0;
    ex_valid  = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    dec_valid = 1'b0; dec_pred = 1'b0; dec_pc = '0; dec_offset = '0;
    ex_valid = 1'b0; ex_taken = 1'b0;
    idle(); idle();
    check_eq("rst_full", full, 0);
    check_eq("rst_flush", flush, 0);
    check_eq("rst_redirect", redirect_pc, 0);
    check_eq("rst_abd", actual_branch_decision, 0);
    check_eq("rst_memsig", branch_mem_sig, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_unf", underflow, 0);
    reset = 1'b0;

    // 1: correct taken prediction
    cyc(1, 1, 32'h84, 32'h10, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    check_eq("t1_memsig", branch_mem_sig, 1);
    check_eq("t1_abd", actual_branch_decision, 1);
    check_eq("t1_flush", flush, 0);
    idle();
    check_eq("t1_memsig_drop", branch_mem_sig, 0);
    check_eq("t1_abd_hold", actual_branch_decision, 1);

    // 2: predicted NT, actually taken; younger entry and same-cycle push are discarded
    cyc(1, 0, 32'h84, 32'h10, 0, 0);
    cyc(1, 1, 32'h200, 32'h40, 0, 0);
    cyc(1, 1, 32'h300, 32'h8, 1, 1);
    check_eq("t2_flush1", flush, 1);
    check_eq("t2_redirect", redirect_pc, 32'h94);
    check_eq("t2_memsig", branch_mem_sig, 1);
    cyc(1, 1, 32'h400, 32'h8, 1, 0);   // ignored during recovery
    check_eq("t2_flush2", flush, 1);
    check_eq("t5_rec_memsig", branch_mem_sig, 0);
    check_eq("t5_rec_unf", underflow, 0);
    check_eq("t5_rec_abd", actual_branch_decision, 1);
    idle();
    check_eq("t2_flush_end", flush, 0);
    check_eq("t2_full", full, 0);

    // 3: predicted T, actually NT -> fall-through; then wrapping target
    cyc(1, 1, 32'h84, 32'h10, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check_eq("t3_flush", flush, 1);
    check_eq("t3_redirect_fall", redirect_pc, 32'h88);
    check_eq("t3_abd", actual_branch_decision, 0);
    idle(); idle();
    check_eq("t3_flush_end", flush, 0);
    check_eq("t3_redirect_hold", redirect_pc, 32'h88);
    cyc(1, 0, 32'hFFFF_FFFC, 32'h8, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    check_eq("t3_redirect_wrap", redirect_pc, 32'h4);
    idle(); idle();
    check_eq("t3_flush_end2", flush, 0);

    // 4: fill, overflow, push+pop while full, drain
    for (int i = 0; i < 4; i++) begin
      check_eq("t4_not_full", full, 0);
      cyc(1, 1, 32'h1000 + 32'(i * 16), 32'h20, 0, 0);
    end
    check_eq("t4_full", full, 1);
    check_eq("t4_ovf_pre", overflow, 0);
    cyc(1, 0, 32'h500, 32'h8, 0, 0);
    check_eq("t4_ovf", overflow, 1);
    check_eq("t4_full_after_drop", full, 1);
    cyc(1, 1, 32'h600, 32'h8, 1, 1);
    check_eq("t4_pushpop_full", full, 1);
    check_eq("t4_pushpop_memsig", branch_mem_sig, 1);
    check_eq("t4_pushpop_flush", flush, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1, 1);
      check_eq("t4_drain_flush", flush, 0);
      check_eq("t4_drain_memsig", branch_mem_sig, 1);
      check_eq("t4_drain_full", full, 0);
    end

    // 5: pop on empty queue
    check_eq("t5_unf_pre", underflow, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check_eq("t5_unf", underflow, 1);
    check_eq("t5_no_memsig", branch_mem_sig, 0);
    check_eq("t5_abd_hold", actual_branch_decision, 1);
    check_eq("t5_ovf_sticky", overflow, 1);

    // reset during recovery aborts the flush immediately
    cyc(1, 0, 32'h84, 32'h10, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    check_eq("rr_flush", flush, 1);
    reset = 1'b1;
    idle();
    check_eq("rr_flush_abort", flush, 0);
    check_eq("rr_redirect", redirect_pc, 0);
    check_eq("rr_ovf", overflow, 0);
    check_eq("rr_unf", underflow, 0);
    reset = 1'b0;
    idle();
    check_eq("rr_flush_stays", flush, 0);

`ifdef BRU_STATS_EN
    // 6: outcomes T/T/NT/T against predictions T/NT/NT/T
    check_eq("t6_br_rst", stat_branches, 0);
    cyc(1, 1, 32'h100, 32'h8, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(1, 0, 32'h200, 32'h8, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    idle(); idle();
    cyc(1, 0, 32'h300, 32'h8, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 1, 32'h400, 32'h8, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    check_eq("t6_branches", stat_branches, 4);
    check_eq("t6_mispredicts", stat_mispredicts, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
